// File: rtl/predictor_table_arbiter_if.sv
// ============================================================================
// Module  : predictor_table_arbiter_if
// Brief   : Fetch/execute/table bundle between the pipeline and the arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface predictor_table_arbiter_if;
    logic        lookup_req;
    logic [31:0] lookup_pc;
    logic        lookup_grant;
    logic        upd_valid;
    logic [31:0] upd_addr;
    logic        upd_result;
    logic        upd_prediction;
    logic        upd_ready;
    logic        flush_req;
    logic        drain_busy;
    logic        tbl_en;
    logic        tbl_we;
    logic [31:0] tbl_addr;
    logic        tbl_taken;
    logic        tbl_mispredict;
    logic        fwd_hit;
    logic        fwd_taken;

    modport master (
        output lookup_req, lookup_pc, upd_valid, upd_addr, upd_result,
               upd_prediction, flush_req,
        input  lookup_grant, upd_ready, drain_busy, tbl_en, tbl_we, tbl_addr,
               tbl_taken, tbl_mispredict, fwd_hit, fwd_taken
    );

    modport slave (
        input  lookup_req, lookup_pc, upd_valid, upd_addr, upd_result,
               upd_prediction, flush_req,
        output lookup_grant, upd_ready, drain_busy, tbl_en, tbl_we, tbl_addr,
               tbl_taken, tbl_mispredict, fwd_hit, fwd_taken
    );
endinterface

`default_nettype wire

// File: rtl/predictor_table_arbiter.sv
// ============================================================================
// Module  : predictor_table_arbiter
// Brief   : Single-port predictor table arbiter with update FIFO, starvation
//           guard and flush drain. BPRED_ARB_FWD_EN enables lookup forwarding.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module predictor_table_arbiter #(
    parameter int QDEPTH       = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    predictor_table_arbiter_if.slave    bus
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    localparam logic [0:0] ST_NORMAL = 1'b0;
    localparam logic [0:0] ST_DRAIN  = 1'b1;

    logic [0:0]    r_state;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [SW-1:0] r_starve;
    logic          r_post_rst;
    logic [31:0]   r_addr [QDEPTH];
    logic          r_res  [QDEPTH];
    logic          r_pred [QDEPTH];

    logic          w_blank;
    logic          w_has;
    logic          w_full;
    logic          w_space;
    logic          w_starved;
    logic          w_upd_issue;
    logic          w_lk_issue;
    logic          w_enq;
    logic [CW-1:0] w_count_next;
    logic [0:0]    w_state_next;

    // Outputs are held quiet during reset and for one cycle after it.
    assign w_blank   = rst | r_post_rst;
    assign w_has     = (r_count != '0);
    assign w_full    = (r_count == CW'(QDEPTH));
    assign w_space   = (r_count < CW'(QDEPTH));
    assign w_starved = (r_starve == SW'(STARVE_LIMIT));

    always_comb begin
        w_upd_issue = 1'b0;
        w_lk_issue  = 1'b0;
        if (!w_blank) begin
            if (r_state == ST_DRAIN) begin
                w_upd_issue = w_has;
            end else if (w_has && (!bus.lookup_req || w_full || w_starved)) begin
                w_upd_issue = 1'b1;
            end else if (bus.lookup_req) begin
                w_lk_issue = 1'b1;
            end
        end
    end

    assign w_enq        = bus.upd_valid && w_space && !rst;
    assign w_count_next = r_count + CW'(w_enq) - CW'(w_upd_issue);

    always_comb begin
        w_state_next = r_state;
        if (bus.flush_req) begin
            w_state_next = (w_count_next != '0) ? ST_DRAIN : ST_NORMAL;
        end else if (r_state == ST_DRAIN && w_count_next == '0) begin
            w_state_next = ST_NORMAL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_NORMAL;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_starve   <= '0;
            r_post_rst <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_count    <= w_count_next;
            r_post_rst <= 1'b0;
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_upd_issue) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_upd_issue || !w_has) begin
                r_starve <= '0;
            end else if (w_lk_issue && !w_starved) begin
                r_starve <= r_starve + SW'(1);
            end
        end
    end

    // Entry storage needs no reset: validity is carried by count and pointers.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_addr[r_wr_ptr] <= bus.upd_addr;
            r_res[r_wr_ptr]  <= bus.upd_result;
            r_pred[r_wr_ptr] <= bus.upd_prediction;
        end
    end

    assign bus.lookup_grant   = w_lk_issue;
    assign bus.tbl_en         = w_upd_issue | w_lk_issue;
    assign bus.tbl_we         = w_upd_issue;
    assign bus.tbl_addr       = w_upd_issue ? r_addr[r_rd_ptr] :
                                w_lk_issue  ? bus.lookup_pc    : 32'h0;
    assign bus.tbl_taken      = w_upd_issue & r_res[r_rd_ptr];
    assign bus.tbl_mispredict = w_upd_issue & (r_res[r_rd_ptr] ^ r_pred[r_rd_ptr]);
    assign bus.drain_busy     = !w_blank && (r_state == ST_DRAIN);
    assign bus.upd_ready      = rst | w_space;

`ifdef BPRED_ARB_FWD_EN
    logic          w_fwd_hit;
    logic          w_fwd_taken;
    logic [PW-1:0] w_fwd_idx;

    // Scan oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        w_fwd_hit   = 1'b0;
        w_fwd_taken = 1'b0;
        w_fwd_idx   = '0;
        for (int i = 0; i < QDEPTH; i++) begin
            w_fwd_idx = r_rd_ptr + PW'(i);
            if ((CW'(i) < r_count) && (r_addr[w_fwd_idx] == bus.lookup_pc)) begin
                w_fwd_hit   = 1'b1;
                w_fwd_taken = r_res[w_fwd_idx];
            end
        end
    end

    assign bus.fwd_hit   = w_lk_issue & w_fwd_hit;
    assign bus.fwd_taken = w_lk_issue & w_fwd_taken;
`else
    assign bus.fwd_hit   = 1'b0;
    assign bus.fwd_taken = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/predictor_table_arbiter.md
PREDICTOR_TABLE_ARBITER -- requirements
Module: predictor_table_arbiter

Interface
REQ-001 Parameter QDEPTH, default 4: update-queue depth in entries, power of two, at least 2.
REQ-002 Parameter STARVE_LIMIT, default 3: maximum consecutive cycles a queued update may lose to lookups.
REQ-003 The block SHALL have one clock (CLK) and one reset (RST), with RST synchronous and active-high.
REQ-004 The ports SHALL be as follows.
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- lookup_req  in  1  fetch requests a table read this cycle
- lookup_pc  in  32  fetch PC (word_t)
- lookup_grant  out  1  table port given to lookup this cycle
- upd_valid  in  1  execute presents a resolved branch
- upd_addr  in  32  branch PC (word_t)
- upd_result  in  1  branch_result, 1 = taken
- upd_prediction  in  1  prediction made at fetch
- upd_ready  out  1  queue can accept an update
- flush_req  in  1  pipeline redirect pulse
- drain_busy  out  1  arbiter is in DRAIN
- tbl_en  out  1  table port active
- tbl_we  out  1  1 = write (update), 0 = read (lookup)
- tbl_addr  out  32  lookup_pc on a read, queue-head addr on a write
- tbl_taken  out  1  queue-head result
- tbl_mispredict  out  1  queue-head result XOR prediction
- fwd_hit  out  1  lookup_pc matches a queued entry
- fwd_taken  out  1  result of the youngest matching entry

Function
REQ-005 The predictor table SHALL be treated as single-ported, with at most one read or one write issued per cycle.
REQ-006 Updates SHALL be buffered in an in-order FIFO of QDEPTH entries {addr, result, prediction}, with count held in log2(QDEPTH)+1 bits.
REQ-007 upd_ready SHALL equal (count < QDEPTH), computed from registered count only.
- A dequeue in the same cycle does not free space early.
REQ-008 An enqueue SHALL occur when upd_valid && upd_ready.
- upd_valid while full is dropped with no state change.
REQ-009 Grant outputs SHALL be combinational from registered state, registered queue, and this cycle's inputs, with zero-cycle latency to tbl_*.
REQ-010 The FSM SHALL have two states: NORMAL and DRAIN.
REQ-011 In NORMAL, an update SHALL issue (tbl_en=1, tbl_we=1, head dequeued) when count>0 and any of the following holds:
- !lookup_req
- count==QDEPTH
- starve_cnt==STARVE_LIMIT
REQ-012 Otherwise, if lookup_req, the lookup SHALL issue (lookup_grant=1, tbl_en=1, tbl_we=0, tbl_addr=lookup_pc).
- If neither condition holds, tbl_en=0.
REQ-013 starve_cnt SHALL behave as follows:
- increments when count>0 and a lookup wins;
- clears when an update issues or count==0;
- saturates at STARVE_LIMIT.
REQ-014 flush_req in any state SHALL move the FSM to DRAIN next cycle if count>0 after this cycle's enqueue/dequeue; otherwise it stays NORMAL.
REQ-015 In DRAIN, the following SHALL hold:
- lookup_grant=0;
- drain_busy=1;
- one update issues every cycle;
- enqueues are still accepted;
- the FSM returns to NORMAL when the post-cycle count is 0.
REQ-016 A simultaneous enqueue and dequeue SHALL leave count unchanged, with pointers wrapping modulo QDEPTH.
REQ-017 When tbl_we=0, the tbl_taken and tbl_mispredict outputs are don't-care and SHALL be driven 0.

Reset
REQ-018 RST SHALL take priority over all inputs, including mid-DRAIN, and apply the following on the next edge:
- state=NORMAL
- count=0
- pointers=0
- starve_cnt=0
- queued entries discarded
REQ-019 While RST is high and on the first cycle after reset, all outputs SHALL be driven as follows:
- lookup_grant=0
- tbl_en=0
- tbl_we=0
- tbl_addr=0
- tbl_taken=0
- tbl_mispredict=0
- drain_busy=0
- fwd_hit=0
- fwd_taken=0
- upd_ready=1

Configuration
REQ-020 Macro BPRED_ARB_FWD_EN SHALL control lookup forwarding.
- Defined: fwd_hit=1 when lookup_grant and lookup_pc equals the addr of any valid queued entry; fwd_taken = result of the youngest match; an entry enqueued this cycle is excluded.
- Undefined: fwd_hit=0 and fwd_taken=0 constantly, and no comparators are synthesized.

Verification
REQ-021 Idle, then one update (addr 0x100, result 1, prediction 0) with lookup_req=0 -> next cycle: tbl_we=1, tbl_addr=0x100, tbl_taken=1, tbl_mispredict=1, count 0.
REQ-022 lookup_req held 1 with 1 queued entry -> lookups granted 3 cycles, then the 4th cycle issues the update (lookup_grant=0) and starve_cnt clears.
REQ-023 4 updates enqueued under continuous lookup -> upd_ready=0 at count 4, a 5th upd_valid is dropped, and the next cycle forces an update.
REQ-024 3 entries queued and flush_req pulsed with lookup_req=1 -> drain_busy=1 for 3 cycles with 3 writes in order, then NORMAL, then lookup_grant=1.
REQ-025 RST asserted mid-DRAIN with 2 entries -> next cycle count=0, NORMAL, tbl_en=0, and no queued write ever issues.
REQ-026 With BPRED_ARB_FWD_EN, entries 0x200 taken then 0x200 not-taken queued, and a lookup of 0x200 -> fwd_hit=1 and fwd_taken=0; without the macro -> fwd_hit=0.
